// File: rtl/dmem_port_arbiter.sv
// Arbitrates BRAM port B between the core MEM stage and an external master.
// Define ARB_PERF_CNT_EN to add saturating performance counter outputs.
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic [3:0]  core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_rvalid,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic [3:0]  ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] rdata,
  output logic [3:0]  bram_web,
  output logic [31:0] bram_addrb,
  output logic [31:0] bram_dib,
  input  logic [31:0] bram_dob
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_core_stall_cnt,
  output logic [31:0] perf_ext_grant_cnt,
  output logic [31:0] perf_lock_cycles
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {ARB, LOCK} state_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_CORE, SEL_EXT} rsel_e;

  state_e            state_q, state_d;
  rsel_e             rsel_q, rsel_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lock_active;
  logic              core_gnt;

  // Grant decision, port mux and next-state logic
  always_comb begin
    lock_active = (state_q == LOCK) && ext_lock;
    ext_gnt     = 1'b0;
    core_gnt    = 1'b0;
    bram_web    = 4'b0;
    bram_addrb  = 32'b0;
    bram_dib    = 32'b0;
    state_d     = state_q;
    rsel_d      = SEL_NONE;
    wait_cnt_d  = wait_cnt_q;

    if (lock_active) begin
      ext_gnt = ext_req;
    end else begin
      ext_gnt  = ext_req && (!core_req || (wait_cnt_q == WAIT_LAST));
      core_gnt = core_req && !ext_gnt;
    end

    if (ext_gnt) begin
      bram_web   = ext_we;
      bram_addrb = ext_addr;
      bram_dib   = ext_wdata;
      if (ext_we == 4'b0) rsel_d = SEL_EXT;
    end else if (core_gnt) begin
      bram_web   = core_we;
      bram_addrb = core_addr;
      bram_dib   = core_wdata;
      if (core_we == 4'b0) rsel_d = SEL_CORE;
    end

    core_stall = core_req && !core_gnt;

    // Starvation counter saturates one short of MAX_WAIT, forcing the next grant
    if (!ext_req || ext_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_LAST) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    // Leaving LOCK happens in the same cycle ext_lock drops
    if (lock_active || (ext_gnt && ext_lock)) begin
      state_d = LOCK;
    end else begin
      state_d = ARB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rsel_q     <= SEL_NONE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rsel_q     <= rsel_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign core_rvalid = (rsel_q == SEL_CORE);
  assign ext_rvalid  = (rsel_q == SEL_EXT);
  assign rdata       = bram_dob;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] egnt_cnt_q, egnt_cnt_d;
  logic [31:0] lock_cnt_q, lock_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    egnt_cnt_d  = egnt_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    if (core_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ext_gnt && (egnt_cnt_q != 32'hFFFF_FFFF))     egnt_cnt_d  = egnt_cnt_q + 32'd1;
    if ((state_q == LOCK) && (lock_cnt_q != 32'hFFFF_FFFF)) lock_cnt_d = lock_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      egnt_cnt_q  <= 32'd0;
      lock_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      egnt_cnt_q  <= egnt_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign perf_core_stall_cnt = stall_cnt_q;
  assign perf_ext_grant_cnt  = egnt_cnt_q;
  assign perf_lock_cycles    = lock_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: BRAM model, rule-level reference arbiter and a read-data scoreboard.
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, ext_req = 1'b0, ext_lock = 1'b0;
  logic [3:0]  core_we = 4'h0, ext_we = 4'h0;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0, ext_addr = 32'h0, ext_wdata = 32'h0;
  logic        core_stall, core_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] rdata, bram_addrb, bram_dib;
  logic [3:0]  bram_web;
  logic [31:0] bram_dob = 32'h0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .rdata(rdata), .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dib(bram_dib),
    .bram_dob(bram_dob)
  );

  function automatic logic [31:0] pat(input int i);
    if (i == 16) return 32'hDEAD_BEEF;
    return (32'h0101_0101 * 32'(i)) ^ 32'hA5A5_0000;
  endfunction

  // Synchronous read-before-write BRAM port, 64 words
  logic        mem_load = 1'b1;
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (bram_web[b]) mem[bram_addrb[7:2]][b*8 +: 8] <= bram_dib[b*8 +: 8];
    end
    bram_dob <= mem[bram_addrb[7:2]];
  end

  typedef struct { bit is_ext; logic [31:0] data; int due; } rd_t;
  rd_t         rq[$];
  logic [31:0] ref_mem [64];
  bit          m_lock, last_eg, last_cg, dut_eg_last;
  logic [3:0]  dut_web_last;
  int          m_wait;
  int          checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbiter evaluated once per cycle on the current inputs
  task automatic model_cycle();
    bit eff, eg, cg;
    logic [3:0] xw;
    logic [31:0] xa, xd;
    int idx;
    eff = m_lock && ext_lock;
    if (eff) begin
      eg = ext_req; cg = 1'b0;
    end else begin
      eg = ext_req && (!core_req || m_wait >= MAX_WAIT - 1);
      cg = core_req && !eg;
    end
    xw = 4'h0; xa = 32'h0; xd = 32'h0;
    if (eg) begin xw = ext_we; xa = ext_addr; xd = ext_wdata; end
    else if (cg) begin xw = core_we; xa = core_addr; xd = core_wdata; end
    chk("ext_gnt", 32'(ext_gnt), 32'(eg));
    chk("core_stall", 32'(core_stall), 32'(core_req && !cg));
    chk("bram_web", 32'(bram_web), 32'(xw));
    chk("bram_addrb", bram_addrb, xa);
    chk("bram_dib", bram_dib, xd);
    dut_eg_last  = ext_gnt;
    dut_web_last = bram_web;
    if (eg || cg) begin
      idx = int'(xa[7:2]);
      if (xw == 4'h0) rq.push_back('{eg, ref_mem[idx], cyc + 1});
      else for (int b = 0; b < 4; b++) if (xw[b]) ref_mem[idx][b*8 +: 8] = xd[b*8 +: 8];
    end
    if (ext_req && !eg) m_wait = (m_wait < MAX_WAIT - 1) ? m_wait + 1 : m_wait;
    else m_wait = 0;
    m_lock  = eff || (eg && ext_lock);
    last_eg = eg;
    last_cg = cg;
  endtask

  task automatic model_reset();
    m_lock = 0; m_wait = 0; last_eg = 0; last_cg = 0;
    rq.delete();
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor: pops the scoreboard whenever an rvalid is presented
  always @(negedge clk) begin
    rd_t e;
    if (core_rvalid || ext_rvalid) begin
      if (rq.size() == 0 || rq[0].due != cyc) begin
        checks++; failures++;
        $display("FAIL unexpected_rvalid: got core=%0b ext=%0b expected none", core_rvalid, ext_rvalid);
      end else begin
        e = rq.pop_front();
        chk("rvalid_core", 32'(core_rvalid), 32'(!e.is_ext));
        chk("rvalid_ext", 32'(ext_rvalid), 32'(e.is_ext));
        chk("rdata", rdata, e.data);
      end
    end else if (rq.size() != 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      checks++; failures++;
      $display("FAIL missing_rvalid: got none expected %s read %h", e.is_ext ? "ext" : "core", e.data);
    end
  end

  task automatic rand_inputs();
    if (!(core_req && !last_cg)) begin
      core_req   = ($urandom % 3) != 0;
      core_we    = ($urandom % 2) ? 4'h0 : 4'($urandom);
      core_addr  = {24'h0, 6'($urandom), 2'b00};
      core_wdata = $urandom;
    end
    if (!(ext_req && !last_eg)) begin
      ext_req   = ($urandom % 3) == 0;
      ext_we    = ($urandom % 2) ? 4'h0 : 4'($urandom);
      ext_addr  = {24'h0, 6'($urandom), 2'b00};
      ext_wdata = $urandom;
    end
    ext_lock = m_lock ? (($urandom % 8) != 0) : (($urandom % 6) == 0);
  endtask

  initial begin
    int gnt_at;
    int words;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_rvalid", 32'(core_rvalid), 32'h0);
    chk("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
    chk("rst_bram_web", 32'(bram_web), 32'h0);
    chk("rst_bram_addrb", bram_addrb, 32'h0);
    chk("rst_bram_dib", bram_dib, 32'h0);
    chk("rst_ext_gnt", 32'(ext_gnt), 32'h0);
    chk("rst_core_stall", 32'(core_stall), 32'h0);
    mem_load = 1'b0;
    rst_n = 1'b1;

    // Core-only read of the preloaded word
    core_req = 1; core_we = 4'h0; core_addr = 32'h40;
    step();
    chk("core_read_rvalid", 32'(core_rvalid), 32'h1);
    chk("core_read_ext_rvalid", 32'(ext_rvalid), 32'h0);
    chk("core_read_rdata", rdata, 32'hDEAD_BEEF);
    core_req = 0;
    step();

    // Both requesting continuously: external forced on the MAX_WAIT-th cycle
    core_req = 1; core_we = 4'h0; core_addr = 32'h10;
    ext_req = 1; ext_we = 4'h0; ext_addr = 32'h20; ext_lock = 0;
    gnt_at = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (dut_eg_last) begin gnt_at = n; break; end
    end
    chk("starve_grant_cycle", 32'(gnt_at), 32'(MAX_WAIT));
    ext_req = 0;
    step();
    core_req = 0;
    step();

    // Locked program load with a stalled masked core write behind it
    ext_req = 1; ext_lock = 1; ext_we = 4'hF; ext_wdata = 32'h1122_3344; ext_addr = 32'h0;
    words = 0;
    for (int n = 0; n < 20 && words < 4; n++) begin
      step();
      if (last_eg) begin
        words++;
        ext_addr = ext_addr + 32'h4;
        core_req = 1; core_we = 4'b0010; core_addr = 32'h40; core_wdata = 32'h0000_AA00;
      end
    end
    chk("lock_words_granted", 32'(words), 32'd4);
    chk("masked_byte_unchanged", mem[16], 32'hDEAD_BEEF);
    chk("lock_word1_landed", mem[1], 32'h1122_3344);
    ext_lock = 0; ext_req = 0;
    step();
    chk("lock_release_core_web", 32'(dut_web_last), 32'h2);
    core_we = 4'h0;
    for (int a = 0; a < 5; a++) begin
      core_addr = (a == 4) ? 32'h40 : 32'(a * 4);
      step();
    end
    core_req = 0;
    step();

    // Reset while in LOCK with an external read outstanding
    ext_req = 1; ext_lock = 1; ext_we = 4'h0; ext_addr = 32'h4;
    step();
    ext_addr = 32'h8;
    step();
    chk("pre_reset_ext_rvalid", 32'(ext_rvalid), 32'h1);
    rst_n = 0;
    #1;
    chk("reset_core_rvalid", 32'(core_rvalid), 32'h0);
    chk("reset_ext_rvalid", 32'(ext_rvalid), 32'h0);
    model_reset();
    core_req = 1; core_we = 4'h0; core_addr = 32'hC;
    @(posedge clk);
    #1;
    rst_n = 1;
    step();
    chk("post_reset_core_first", 32'(last_cg), 32'h1);
    core_req = 0; ext_req = 0; ext_lock = 0;
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      step();
    end

    core_req = 0; ext_req = 0; ext_lock = 0;
    repeat (3) step();
    chk("scoreboard_drained", 32'(rq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
